winograd_result_accumulator: RTL and testbench

- Sits directly downstream of the Winograd PE and consumes its output tile stream (result tile, result address, result valid).
- Sums partial output tiles that share a result address across input channels (ID) into an on-chip tile buffer.
- When an address has received its full channel count, it releases the finished tile to the output writer through a valid/ready interface.
- The PE cannot be stalled, so this block accepts one input tile every cycle and never applies backpressure upstream.

---
 rtl/winograd_result_accumulator.sv | 146 ++++++++++++++
 tb/tb_winograd_result_accumulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/winograd_result_accumulator.sv
// Sums Winograd PE partial tiles per result address across input channels
// and streams finished tiles out through a valid/ready stage.
//
// Ports:
//   clk, reset (async, active-low)
//   result_tile_i / result_valid_i / result_address_i : PE tile stream
//   size_type_i (0 = 6x6, 1 = 4x4), id_count_i : partials per address
//   acc_tile_o / acc_valid_o / acc_ready_i / acc_address_o : output stream
//   sat_flag_o, lock_err_o : sticky status; pending_o : queued tiles
// Tiles are flattened row-major: element r*6+c.
module winograd_result_accumulator #(
  parameter int IN_W  = 12,
  parameter int ACC_W = 16,
  parameter int DEPTH = 256,
  parameter int CNT_W = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [35:0][IN_W-1:0]       result_tile_i,
  input  logic                        result_valid_i,
  input  logic [7:0]                  result_address_i,
  input  logic                        size_type_i,
  input  logic [CNT_W-1:0]            id_count_i,
  output logic [35:0][ACC_W-1:0]      acc_tile_o,
  output logic                        acc_valid_o,
  input  logic                        acc_ready_i,
  output logic [7:0]                  acc_address_o,
  output logic                        sat_flag_o,
  output logic                        lock_err_o,
  output logic [8:0]                  pending_o
);

  localparam logic signed [ACC_W:0] SMAX =
    {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN =
    {2'b11, {(ACC_W-1){1'b0}}};

  logic [35:0][ACC_W-1:0] tile_mem [DEPTH];
  logic [CNT_W-1:0]       cnt_mem  [DEPTH];
  logic [DEPTH-1:0]       lock_mem;
  logic [7:0]             fifo_mem [DEPTH];
  logic [7:0]             wr_ptr;
  logic [7:0]             rd_ptr;
  logic [8:0]             fifo_cnt;

  logic [7:0]             head;
  logic                   load;
  logic                   hit_load;
  logic                   is_locked;
  logic                   accept;
  logic                   done;
  logic                   push;
  logic                   sat_hit;
  logic [35:0][ACC_W-1:0] base_tile;
  logic [CNT_W-1:0]       cnt_base;
  logic [CNT_W:0]         new_cnt;
  logic [CNT_W-1:0]       need;
  logic [35:0][ACC_W-1:0] new_tile;
  logic signed [ACC_W:0]  sum_w [36];

  function automatic logic masked(input int i, input logic sz);
    return sz && (((i / 6) >= 4) || ((i % 6) >= 4));
  endfunction

  assign head = fifo_mem[rd_ptr];
  assign load = (fifo_cnt != '0) &&
                (!acc_valid_o || acc_ready_i);
  // An entry unloaded on this edge is free again for the input.
  assign hit_load  = load && (result_address_i == head);
  assign is_locked = lock_mem[result_address_i] && !hit_load;
  assign accept    = result_valid_i && !is_locked;

  assign base_tile = hit_load ? '0 : tile_mem[result_address_i];
  assign cnt_base  = hit_load ? '0 : cnt_mem[result_address_i];
  assign new_cnt   = (CNT_W+1)'(cnt_base) + (CNT_W+1)'(1);
  assign need      = (id_count_i == '0) ? CNT_W'(1) : id_count_i;
  assign done      = new_cnt >= {1'b0, need};
  assign push      = accept && done;
  assign pending_o = fifo_cnt;

  always_comb begin
    new_tile = '0;
    sat_hit  = 1'b0;
    for (int i = 0; i < 36; i++) begin
      sum_w[i] = {base_tile[i][ACC_W-1], base_tile[i]};
      if (!masked(i, size_type_i))
        sum_w[i] = sum_w[i] +
          {{(ACC_W+1-IN_W){result_tile_i[i][IN_W-1]}},
           result_tile_i[i]};
      if (sum_w[i] > SMAX) begin
        new_tile[i] = SMAX[ACC_W-1:0];
        sat_hit     = 1'b1;
      end else if (sum_w[i] < SMIN) begin
        new_tile[i] = SMIN[ACC_W-1:0];
        sat_hit     = 1'b1;
      end else begin
        new_tile[i] = sum_w[i][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tile_mem      <= '{default: '0};
      cnt_mem       <= '{default: '0};
      fifo_mem      <= '{default: '0};
      lock_mem      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      acc_tile_o    <= '0;
      acc_valid_o   <= 1'b0;
      acc_address_o <= '0;
      sat_flag_o    <= 1'b0;
      lock_err_o    <= 1'b0;
    end else begin
      if (load) begin
        acc_tile_o     <= tile_mem[head];
        acc_address_o  <= head;
        acc_valid_o    <= 1'b1;
        tile_mem[head] <= '0;
        cnt_mem[head]  <= '0;
        lock_mem[head] <= 1'b0;
        rd_ptr         <= rd_ptr + 8'd1;
      end else if (acc_valid_o && acc_ready_i) begin
        acc_valid_o <= 1'b0;
      end
      // Input writes come after the unload clear so they win.
      if (result_valid_i && is_locked)
        lock_err_o <= 1'b1;
      if (accept) begin
        tile_mem[result_address_i] <= new_tile;
        cnt_mem[result_address_i]  <= new_cnt[CNT_W-1:0];
        if (sat_hit)
          sat_flag_o <= 1'b1;
        if (done) begin
          lock_mem[result_address_i] <= 1'b1;
          fifo_mem[wr_ptr]           <= result_address_i;
          wr_ptr                     <= wr_ptr + 8'd1;
        end
      end
      fifo_cnt <= fifo_cnt + 9'(push) - 9'(load);
    end
  end

endmodule

// File: tb/tb_winograd_result_accumulator.sv
// Directed bench for winograd_result_accumulator.
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_winograd_result_accumulator;

  localparam int IN_W  = 12;
  localparam int ACC_W = 16;
  localparam int CNT_W = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [35:0][IN_W-1:0]  result_tile_i;
  logic                   result_valid_i;
  logic [7:0]             result_address_i;
  logic                   size_type_i;
  logic [CNT_W-1:0]       id_count_i;
  logic [35:0][ACC_W-1:0] acc_tile_o;
  logic                   acc_valid_o;
  logic                   acc_ready_i;
  logic [7:0]             acc_address_o;
  logic                   sat_flag_o;
  logic                   lock_err_o;
  logic [8:0]             pending_o;

  int checks = 0;
  int errors = 0;

  winograd_result_accumulator #(
    .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(256), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .result_tile_i(result_tile_i),
    .result_valid_i(result_valid_i),
    .result_address_i(result_address_i),
    .size_type_i(size_type_i),
    .id_count_i(id_count_i),
    .acc_tile_o(acc_tile_o),
    .acc_valid_o(acc_valid_o),
    .acc_ready_i(acc_ready_i),
    .acc_address_o(acc_address_o),
    .sat_flag_o(sat_flag_o),
    .lock_err_o(lock_err_o),
    .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0][IN_W-1:0] fill(
      input logic [IN_W-1:0] v);
    logic [35:0][IN_W-1:0] t;
    for (int i = 0; i < 36; i++) t[i] = v;
    return t;
  endfunction

  function automatic logic [31:0] el(input int i);
    return 32'(acc_tile_o[i]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a,
                      input logic [IN_W-1:0] v);
    result_valid_i   = 1'b1;
    result_address_i = a;
    result_tile_i    = fill(v);
    tick();
    result_valid_i   = 1'b0;
  endtask

  task automatic idle();
    result_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    reset            = 1'b0;
    result_tile_i    = '0;
    result_valid_i   = 1'b0;
    result_address_i = '0;
    size_type_i      = 1'b0;
    id_count_i       = '0;
    acc_ready_i      = 1'b1;
    #12 reset = 1'b1;
    tick();
    chk("rst_valid", 32'(acc_valid_o), 0);
    chk("rst_pend",  32'(pending_o), 0);
    chk("rst_tile",  el(0), 0);
    chk("rst_flags", 32'({sat_flag_o, lock_err_o}), 0);

    // four channels of 100 -> 400
    id_count_i = 5'd4;
    repeat (4) send(8'd7, 12'd100);
    chk("t1_pend", 32'(pending_o), 1);
    chk("t1_early", 32'(acc_valid_o), 0);
    idle();
    chk("t1_valid", 32'(acc_valid_o), 1);
    chk("t1_addr", 32'(acc_address_o), 7);
    chk("t1_e0", el(0), 32'd400);
    chk("t1_e35", el(35), 32'd400);
    chk("t1_pend0", 32'(pending_o), 0);
    idle();
    chk("t1_drop", 32'(acc_valid_o), 0);

    // 4x4 mask: 16 x 2047 = 32752, just below the clamp
    size_type_i = 1'b1;
    id_count_i  = 5'd16;
    repeat (16) send(8'd3, 12'd2047);
    idle();
    chk("t2_addr", 32'(acc_address_o), 3);
    chk("t2_e0", el(0), 32'h7FF0);
    chk("t2_e21", el(21), 32'h7FF0);
    chk("t2_c4", el(4), 0);
    chk("t2_r5", el(30), 0);
    chk("t2_nosat", 32'(sat_flag_o), 0);
    idle();

    // 20 x -2048 = -40960 clamps to -32768
    size_type_i = 1'b0;
    id_count_i  = 5'd20;
    repeat (20) send(8'd4, 12'h800);
    idle();
    chk("sat_e0", el(0), 32'h8000);
    chk("sat_e35", el(35), 32'h8000);
    chk("sat_flag", 32'(sat_flag_o), 1);
    idle();

    // load-cycle reuse of address 9
    id_count_i = 5'd2;
    send(8'd9, 12'd1);
    send(8'd9, 12'd2);
    chk("t5_pend", 32'(pending_o), 1);
    send(8'd9, 12'd10);
    chk("t5_addr", 32'(acc_address_o), 9);
    chk("t5_first", el(0), 32'd3);
    send(8'd9, 12'd20);
    chk("t5_gap", 32'(acc_valid_o), 0);
    idle();
    chk("t5_second", el(0), 32'd30);
    chk("t5_nolock", 32'(lock_err_o), 0);
    idle();

    // interleaved addresses 0 and 1
    send(8'd0, 12'd1);
    send(8'd1, 12'd2);
    send(8'd0, 12'd3);
    send(8'd1, 12'd4);
    chk("il_a0", 32'(acc_address_o), 0);
    chk("il_v0", el(0), 32'd4);
    idle();
    chk("il_a1", 32'(acc_address_o), 1);
    chk("il_v1", el(0), 32'd6);
    idle();

    // backpressure
    acc_ready_i = 1'b0;
    id_count_i  = 5'd1;
    send(8'd1, 12'd11);
    chk("bp_p1", 32'(pending_o), 1);
    send(8'd2, 12'd22);
    chk("bp_a1", 32'(acc_address_o), 1);
    send(8'd3, 12'd33);
    chk("bp_p2", 32'(pending_o), 2);
    idle();
    idle();
    chk("bp_hold_a", 32'(acc_address_o), 1);
    chk("bp_hold_v", el(0), 32'd11);
    chk("bp_hold_p", 32'(pending_o), 2);
    acc_ready_i = 1'b1;
    idle();
    chk("bp_a2", 32'(acc_address_o), 2);
    chk("bp_v2", el(0), 32'd22);
    idle();
    chk("bp_a3", 32'(acc_address_o), 3);
    chk("bp_v3", el(0), 32'd33);
    idle();
    chk("bp_done", 32'(acc_valid_o), 0);

    // locked entry
    acc_ready_i = 1'b0;
    send(8'd6, 12'd5);
    send(8'd5, 12'd7);
    send(8'd5, 12'd50);
    chk("lk_err", 32'(lock_err_o), 1);
    chk("lk_pend", 32'(pending_o), 1);
    chk("lk_head", 32'(acc_address_o), 6);
    acc_ready_i = 1'b1;
    idle();
    chk("lk_a5", 32'(acc_address_o), 5);
    chk("lk_v5", el(0), 32'd7);
    idle();

    // asynchronous reset mid-stream
    acc_ready_i = 1'b0;
    id_count_i  = 5'd2;
    send(8'd2, 12'd100);
    id_count_i  = 5'd1;
    send(8'd8, 12'd9);
    idle();
    chk("ar_pre", 32'(acc_valid_o), 1);
    #3 reset = 1'b0;
    #1;
    chk("ar_valid", 32'(acc_valid_o), 0);
    chk("ar_tile", el(0), 0);
    chk("ar_addr", 32'(acc_address_o), 0);
    chk("ar_flags", 32'({sat_flag_o, lock_err_o}), 0);
    #2 reset = 1'b1;
    tick();
    acc_ready_i = 1'b1;
    id_count_i  = 5'd2;
    send(8'd2, 12'd5);
    send(8'd2, 12'd5);
    idle();
    chk("ar_a2", 32'(acc_address_o), 2);
    chk("ar_v2", el(0), 32'd10);
    chk("ar_pend", 32'(pending_o), 0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
